ibex_xif_ex_issue_ctrl: RTL and testbench
=========================================

Name: ibex_xif_ex_issue_ctrl

Overview:
Issue-side controller that drives the execution block (ALU plus MUL/DIV) and consumes its results.
- Accepts one operation at a time from the ID-side valid/ready issue port and holds operands stable for the whole EX operation.
- Sequences the enable/select/first-cycle controls and owns the 2x34-bit intermediate value register.
- Captures the result on ex_valid and presents it on a valid/ready writeback port.

Parameters:
RV32M, ibex_xif_pkg::RV32MFast, multdiv configuration; when RV32MNone, MULT/DIV issue classes are illegal and mult/div controls are tied 0.
ResetAll, 1'b0, when 1 the operand and result datapath registers are also reset (controls are always reset).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
issue_valid_i  in  1  operation request
issue_ready_o  out  1  request accepted when valid & ready
issue_class_i  in  2  ex_class_e: ALU=0, MULT=1, DIV=2
issue_alu_op_i  in  alu_op_e  ALU operator
issue_md_op_i  in  md_op_e  multdiv operator
issue_signed_mode_i  in  2  multdiv signedness
issue_op_a_i / issue_op_b_i  in  32 each  operands
flush_i  in  1  kill in-flight operation
alu_operator_o, alu_operand_a_o, alu_operand_b_o  out  alu_op_e/32/32  to EX
alu_instr_first_cycle_o  out  1  first EXEC cycle
multdiv_operator_o, multdiv_signed_mode_o  out  md_op_e/2  to EX
multdiv_operand_a_o / multdiv_operand_b_o  out  32 each  to EX
mult_en_o, div_en_o, mult_sel_o, div_sel_o  out  1 each  multdiv controls
multdiv_ready_id_o  out  1  consumer ready for multdiv result
imd_val_we_i  in  2  intermediate register write enables
imd_val_d_i  in  2x34  intermediate register next values
imd_val_q_o  out  2x34  intermediate register contents
result_ex_i  in  32  EX result
ex_valid_i  in  1  EX result valid
wb_valid_o  out  1  result available
wb_ready_i  in  1  writeback consumer ready
wb_result_o  out  32  captured result

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, issue_ready_o=1, wb_valid_o=0.
  - All en/sel/first_cycle outputs 0; imd_val_q_o=0.
  - wb_result_o and operand outputs 0 only when ResetAll=1, otherwise X-tolerant.
- State machine (ex_state_e):
  - IDLE: issue_ready_o = ~flush_i. On accept, register class, ops and operands; go to EXEC with first_flag=1.
  - EXEC:
    - alu_instr_first_cycle_o = first_flag; first_flag clears after the first EXEC cycle.
    - mult_sel_o = (class==MULT); div_sel_o = (class==DIV).
    - mult_en_o = mult_sel_o & ~flush_i; div_en_o = div_sel_o & ~flush_i.
    - multdiv_ready_id_o=1.
    - On ex_valid_i & ~flush_i: capture result_ex_i into wb_result, go to WB.
  - WB:
    - wb_valid_o=1; en/sel/first_cycle outputs 0; multdiv_ready_id_o=0.
    - On wb_ready_i: if issue_valid_i, accept the next op into EXEC (back-to-back, issue_ready_o = wb_ready_i & ~flush_i); else go to IDLE.
- Intermediate value register:
  - Each imd_val_we_i[k] in EXEC writes imd_val_d_i[k] next cycle.
  - Writes are ignored outside EXEC.
  - Cleared to 0 on every issue accept.
- Latency: a single-cycle ALU op accepted in cycle N reaches EXEC at N+1 and gives wb_valid_o at N+2. Multi-cycle ops take 1 + EX cycles.
- Operand and operator outputs stay stable from the accept until leaving EXEC.
- flush_i:
  - From any state, go to IDLE next cycle and drop wb_valid_o.
  - Flush beats ex_valid_i and issue_valid_i in the same cycle.
  - Clear the imd register.
- Illegal class (3, or MULT/DIV with RV32MNone): treated as ALU.
- Asynchronous reset during EXEC abandons the operation with no writeback.

Optional Feature:
IBEX_XIF_EX_ISSUE_PERF_EN:
- Defined: adds outputs perf_ex_busy_o (32) and perf_wb_stall_o (32).
  - perf_ex_busy_o counts EXEC cycles; perf_wb_stall_o counts WB cycles with ~wb_ready_i.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters are absent.

Decomposition:
- ibex_xif_pkg: ex_class_e (ALU/MULT/DIV), ex_state_e (IDLE/EXEC/WB), IMD_W=34 constant; alu_op_e and md_op_e are reused from the package.
- Sub-module ibex_xif_ex_imd_reg holds the two 34-bit registers with per-entry write enable and clear.

Test Plan:
- ALU ADD, a=5, b=7; EX returns 12 with ex_valid_i in the first EXEC cycle; wb_ready_i=1 -> wb_valid_o at N+2, wb_result_o=12, first_cycle high exactly one cycle.
- MULT class; EX asserts imd_val_we_i=2'b01 with d0=34'h1_2345_6789, then ex_valid_i after 3 cycles -> mult_en_o high 4 cycles, imd_val_q_o[0]=34'h1_2345_6789, operands stable throughout.
- wb_ready_i held 0 for 5 cycles -> wb_valid_o and wb_result_o held, issue_ready_o=0, mult_en_o=0; back-to-back issue accepted in the cycle wb_ready_i rises.
- flush_i asserted during the 2nd EXEC cycle of a DIV, with ex_valid_i=1 the same cycle -> no wb_valid_o, state=IDLE next cycle, imd_val_q_o=0.
- rst_i pulsed asynchronously mid-EXEC -> all outputs at reset values immediately, issue_ready_o=1 after release.
- With IBEX_XIF_EX_ISSUE_PERF_EN defined: 3-cycle op followed by 2 stall cycles -> perf_ex_busy_o=3, perf_wb_stall_o=2.

Source files
------------

// File: rtl/ibex_xif_pkg.sv
// Shared types and constants for the XIF execution issue controller.
package ibex_xif_pkg;

    typedef enum integer {
        RV32MNone,
        RV32MSlow,
        RV32MFast,
        RV32MSingleCycle
    } rv32m_e;

    typedef enum logic [6:0] {
        ALU_ADD = 7'd0,
        ALU_SUB = 7'd1,
        ALU_XOR = 7'd2,
        ALU_OR  = 7'd3,
        ALU_AND = 7'd4,
        ALU_SRA = 7'd5,
        ALU_SRL = 7'd6,
        ALU_SLL = 7'd7,
        ALU_LT  = 7'd8,
        ALU_LTU = 7'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        EX_CLASS_ALU  = 2'd0,
        EX_CLASS_MULT = 2'd1,
        EX_CLASS_DIV  = 2'd2
    } ex_class_e;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_EXEC = 2'd1,
        EX_WB   = 2'd2
    } ex_state_e;

    localparam int IMD_W = 34;

    // Unknown encodings, and multdiv classes when multdiv is absent, fall back to ALU.
    function automatic ex_class_e decode_class(input logic [1:0] cls, input bit md_en);
        ex_class_e res;
        res = EX_CLASS_ALU;
        if (md_en && (cls == 2'd1)) begin
            res = EX_CLASS_MULT;
        end else if (md_en && (cls == 2'd2)) begin
            res = EX_CLASS_DIV;
        end
        return res;
    endfunction

endpackage

// File: rtl/ibex_xif_ex_imd_reg.sv
// Two-entry intermediate value register for multi-cycle EX operations,
// per-entry write enable with a synchronous clear that wins over writes.
module ibex_xif_ex_imd_reg
    import ibex_xif_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic [1:0]       we_i,
    input  logic [IMD_W-1:0] d_i [2],
    output logic [IMD_W-1:0] q_o [2]
);

    logic [IMD_W-1:0] imd_q [2];
    logic [IMD_W-1:0] imd_d [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            imd_d[k] = imd_q[k];
            if (clear_i) begin
                imd_d[k] = '0;
            end else if (we_i[k]) begin
                imd_d[k] = d_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            imd_q[0] <= '0;
            imd_q[1] <= '0;
        end else begin
            imd_q[0] <= imd_d[0];
            imd_q[1] <= imd_d[1];
        end
    end

    assign q_o = imd_q;

endmodule

// File: rtl/ibex_xif_ex_issue_ctrl.sv
// Issue-side controller for the ALU/MULDIV execution block: accepts one op,
// sequences EX controls, captures the result for writeback. Optional perf
// counters are enabled with IBEX_XIF_EX_ISSUE_PERF_EN.
module ibex_xif_ex_issue_ctrl
    import ibex_xif_pkg::*;
#(
    parameter rv32m_e RV32M    = RV32MFast,
    parameter bit     ResetAll = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [1:0]       issue_class_i,
    input  alu_op_e          issue_alu_op_i,
    input  md_op_e           issue_md_op_i,
    input  logic [1:0]       issue_signed_mode_i,
    input  logic [31:0]      issue_op_a_i,
    input  logic [31:0]      issue_op_b_i,
    input  logic             flush_i,

    output alu_op_e          alu_operator_o,
    output logic [31:0]      alu_operand_a_o,
    output logic [31:0]      alu_operand_b_o,
    output logic             alu_instr_first_cycle_o,
    output md_op_e           multdiv_operator_o,
    output logic [1:0]       multdiv_signed_mode_o,
    output logic [31:0]      multdiv_operand_a_o,
    output logic [31:0]      multdiv_operand_b_o,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             mult_sel_o,
    output logic             div_sel_o,
    output logic             multdiv_ready_id_o,

    input  logic [1:0]       imd_val_we_i,
    input  logic [IMD_W-1:0] imd_val_d_i [2],
    output logic [IMD_W-1:0] imd_val_q_o [2],

    input  logic [31:0]      result_ex_i,
    input  logic             ex_valid_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [31:0]      wb_result_o,

`ifdef IBEX_XIF_EX_ISSUE_PERF_EN
    output logic [31:0]      perf_ex_busy_o,
    output logic [31:0]      perf_wb_stall_o,
`endif
    output ex_state_e        ex_state_o
);

    localparam bit MdEnabled = (RV32M != RV32MNone);

    ex_state_e   state_q, state_d;
    logic        first_flag_q, first_flag_d;
    ex_class_e   class_q, class_d;
    alu_op_e     alu_op_q, alu_op_d;
    md_op_e      md_op_q, md_op_d;
    logic [1:0]  signed_q, signed_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] wb_result_q, wb_result_d;

    logic accept;
    logic in_exec;
    logic capture;
    logic imd_clear;
    logic [1:0] imd_we;

    // Issue handshake: an op transfers on issue_valid_i & issue_ready_o; flush always blocks it.
    always_comb begin
        issue_ready_o = 1'b0;
        case (state_q)
            EX_IDLE: issue_ready_o = ~flush_i;
            EX_WB:   issue_ready_o = wb_ready_i & ~flush_i;
            default: issue_ready_o = 1'b0;
        endcase
    end

    assign accept  = issue_valid_i & issue_ready_o;
    assign in_exec = (state_q == EX_EXEC);
    assign capture = in_exec & ex_valid_i & ~flush_i;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EX_IDLE;
        end else begin
            case (state_q)
                EX_IDLE: if (accept) state_d = EX_EXEC;
                EX_EXEC: if (ex_valid_i) state_d = EX_WB;
                EX_WB: begin
                    if (wb_ready_i) begin
                        state_d = accept ? EX_EXEC : EX_IDLE;
                    end
                end
                default: state_d = EX_IDLE;
            endcase
        end
    end

    // Only an accept can lead into EXEC, so the flag is simply the registered accept.
    assign first_flag_d = accept;

    always_comb begin
        class_d     = class_q;
        alu_op_d    = alu_op_q;
        md_op_d     = md_op_q;
        signed_d    = signed_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        wb_result_d = wb_result_q;
        if (accept) begin
            class_d  = decode_class(issue_class_i, MdEnabled);
            alu_op_d = issue_alu_op_i;
            md_op_d  = issue_md_op_i;
            signed_d = issue_signed_mode_i;
            op_a_d   = issue_op_a_i;
            op_b_d   = issue_op_b_i;
        end
        if (capture) begin
            wb_result_d = result_ex_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= EX_IDLE;
            first_flag_q <= 1'b0;
            class_q      <= EX_CLASS_ALU;
            alu_op_q     <= ALU_ADD;
            md_op_q      <= MD_OP_MULL;
            signed_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            first_flag_q <= first_flag_d;
            class_q      <= class_d;
            alu_op_q     <= alu_op_d;
            md_op_q      <= md_op_d;
            signed_q     <= signed_d;
        end
    end

    if (ResetAll) begin : g_dp_reset
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                op_a_q      <= '0;
                op_b_q      <= '0;
                wb_result_q <= '0;
            end else begin
                op_a_q      <= op_a_d;
                op_b_q      <= op_b_d;
                wb_result_q <= wb_result_d;
            end
        end
    end else begin : g_dp_noreset
        always_ff @(posedge clk_i) begin
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            wb_result_q <= wb_result_d;
        end
    end

    always_comb begin
        alu_instr_first_cycle_o = in_exec & first_flag_q;
        mult_sel_o              = 1'b0;
        div_sel_o               = 1'b0;
        if (MdEnabled) begin
            mult_sel_o = in_exec & (class_q == EX_CLASS_MULT);
            div_sel_o  = in_exec & (class_q == EX_CLASS_DIV);
        end
        mult_en_o          = mult_sel_o & ~flush_i;
        div_en_o           = div_sel_o & ~flush_i;
        multdiv_ready_id_o = in_exec;
        wb_valid_o         = (state_q == EX_WB);
    end

    assign alu_operator_o        = alu_op_q;
    assign alu_operand_a_o       = op_a_q;
    assign alu_operand_b_o       = op_b_q;
    assign multdiv_operator_o    = md_op_q;
    assign multdiv_signed_mode_o = signed_q;
    assign multdiv_operand_a_o   = op_a_q;
    assign multdiv_operand_b_o   = op_b_q;
    assign wb_result_o           = wb_result_q;
    assign ex_state_o            = state_q;

    assign imd_clear = accept | flush_i;
    assign imd_we    = in_exec ? imd_val_we_i : 2'b00;

    ibex_xif_ex_imd_reg u_imd_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (imd_clear),
        .we_i    (imd_we),
        .d_i     (imd_val_d_i),
        .q_o     (imd_val_q_o)
    );

`ifdef IBEX_XIF_EX_ISSUE_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (in_exec && (perf_busy_q != 32'hFFFF_FFFF)) begin
            perf_busy_d = perf_busy_q + 32'd1;
        end
        if ((state_q == EX_WB) && !wb_ready_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ex_busy_o  = perf_busy_q;
    assign perf_wb_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ibex_xif_ex_issue_ctrl.sv
// Directed self-checking bench for ibex_xif_ex_issue_ctrl.
module tb_ibex_xif_ex_issue_ctrl;
    import ibex_xif_pkg::*;

    logic             clk;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready;
    logic [1:0]       issue_class;
    alu_op_e          issue_alu_op;
    md_op_e           issue_md_op;
    logic [1:0]       issue_signed;
    logic [31:0]      issue_a;
    logic [31:0]      issue_b;
    logic             flush;
    alu_op_e          alu_operator;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic             first_cycle;
    md_op_e           md_operator;
    logic [1:0]       md_signed;
    logic [31:0]      md_a;
    logic [31:0]      md_b;
    logic             mult_en;
    logic             div_en;
    logic             mult_sel;
    logic             div_sel;
    logic             md_ready_id;
    logic [1:0]       imd_we;
    logic [IMD_W-1:0] imd_d [2];
    logic [IMD_W-1:0] imd_q [2];
    logic [31:0]      result_ex;
    logic             ex_valid;
    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_result;
    ex_state_e        ex_state;
`ifdef IBEX_XIF_EX_ISSUE_PERF_EN
    logic [31:0]      perf_busy;
    logic [31:0]      perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ibex_xif_ex_issue_ctrl dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .issue_valid_i           (issue_valid),
        .issue_ready_o           (issue_ready),
        .issue_class_i           (issue_class),
        .issue_alu_op_i          (issue_alu_op),
        .issue_md_op_i           (issue_md_op),
        .issue_signed_mode_i     (issue_signed),
        .issue_op_a_i            (issue_a),
        .issue_op_b_i            (issue_b),
        .flush_i                 (flush),
        .alu_operator_o          (alu_operator),
        .alu_operand_a_o         (alu_a),
        .alu_operand_b_o         (alu_b),
        .alu_instr_first_cycle_o (first_cycle),
        .multdiv_operator_o      (md_operator),
        .multdiv_signed_mode_o   (md_signed),
        .multdiv_operand_a_o     (md_a),
        .multdiv_operand_b_o     (md_b),
        .mult_en_o               (mult_en),
        .div_en_o                (div_en),
        .mult_sel_o              (mult_sel),
        .div_sel_o               (div_sel),
        .multdiv_ready_id_o      (md_ready_id),
        .imd_val_we_i            (imd_we),
        .imd_val_d_i             (imd_d),
        .imd_val_q_o             (imd_q),
        .result_ex_i             (result_ex),
        .ex_valid_i              (ex_valid),
        .wb_valid_o              (wb_valid),
        .wb_ready_i              (wb_ready),
        .wb_result_o             (wb_result),
`ifdef IBEX_XIF_EX_ISSUE_PERF_EN
        .perf_ex_busy_o          (perf_busy),
        .perf_wb_stall_o         (perf_stall),
`endif
        .ex_state_o              (ex_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1-2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        issue_valid  = 1'b0;
        issue_class  = 2'd0;
        issue_alu_op = ALU_ADD;
        issue_md_op  = MD_OP_MULL;
        issue_signed = 2'b00;
        issue_a      = 32'd0;
        issue_b      = 32'd0;
        flush        = 1'b0;
        imd_we       = 2'b00;
        imd_d[0]     = '0;
        imd_d[1]     = '0;
        result_ex    = 32'd0;
        ex_valid     = 1'b0;
        wb_ready     = 1'b0;
    endtask

    task automatic drive_issue(input logic [1:0] cls, input alu_op_e aop, input md_op_e mop,
                               input logic [31:0] a, input logic [31:0] b);
        issue_valid  = 1'b1;
        issue_class  = cls;
        issue_alu_op = aop;
        issue_md_op  = mop;
        issue_signed = 2'b01;
        issue_a      = a;
        issue_b      = b;
    endtask

    initial begin
        quiet_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // Reset state
        check("rst_state", 64'(ex_state), 64'(EX_IDLE));
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_first", 64'(first_cycle), 64'd0);
        check("rst_mult_en", 64'(mult_en), 64'd0);
        check("rst_imd0", 64'(imd_q[0]), 64'd0);

        // ALU ADD 5 + 7, result on first EXEC cycle
        drive_issue(2'd0, ALU_ADD, MD_OP_MULL, 32'd5, 32'd7);
        wb_ready = 1'b1;
        #1 check("alu_accept_ready", 64'(issue_ready), 64'd1);
        tick();
        quiet_inputs();
        wb_ready  = 1'b1;
        ex_valid  = 1'b1;
        result_ex = 32'd12;
        #1;
        check("alu_exec_state", 64'(ex_state), 64'(EX_EXEC));
        check("alu_first_cycle", 64'(first_cycle), 64'd1);
        check("alu_op_a", 64'(alu_a), 64'd5);
        check("alu_op_b", 64'(alu_b), 64'd7);
        check("alu_operator", 64'(alu_operator), 64'(ALU_ADD));
        check("alu_mult_en", 64'(mult_en), 64'd0);
        check("alu_issue_ready_exec", 64'(issue_ready), 64'd0);
        check("alu_md_ready_id", 64'(md_ready_id), 64'd1);
        tick();
        ex_valid  = 1'b0;
        result_ex = 32'hDEAD_BEEF;
        #1;
        check("alu_wb_valid", 64'(wb_valid), 64'd1);
        check("alu_wb_result", 64'(wb_result), 64'd12);
        check("alu_first_low", 64'(first_cycle), 64'd0);
        check("alu_md_ready_wb", 64'(md_ready_id), 64'd0);
        tick();
        #1;
        check("alu_back_idle", 64'(ex_state), 64'(EX_IDLE));
        check("alu_wb_dropped", 64'(wb_valid), 64'd0);

        // MULT with intermediate write, result after 3 more cycles
        wb_ready = 1'b0;
        drive_issue(2'd1, ALU_ADD, MD_OP_MULH, 32'd3, 32'd4);
        tick();
        quiet_inputs();
        imd_we   = 2'b01;
        imd_d[0] = 34'h1_2345_6789;
        imd_d[1] = 34'h3_FFFF_FFFF;
        #1;
        check("mul_c1_en", 64'(mult_en), 64'd1);
        check("mul_c1_sel", 64'(mult_sel), 64'd1);
        check("mul_c1_div_sel", 64'(div_sel), 64'd0);
        check("mul_c1_first", 64'(first_cycle), 64'd1);
        check("mul_operator", 64'(md_operator), 64'(MD_OP_MULH));
        check("mul_signed", 64'(md_signed), 64'd1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            imd_we = 2'b00;
            if (c == 4) begin
                ex_valid  = 1'b1;
                result_ex = 32'd12;
            end
            #1;
            check($sformatf("mul_c%0d_en", c), 64'(mult_en), 64'd1);
            check($sformatf("mul_c%0d_first", c), 64'(first_cycle), 64'd0);
            check($sformatf("mul_c%0d_a", c), 64'(md_a), 64'd3);
            check($sformatf("mul_c%0d_b", c), 64'(md_b), 64'd4);
            check($sformatf("mul_c%0d_imd0", c), 64'(imd_q[0]), 64'h1_2345_6789);
            check($sformatf("mul_c%0d_imd1", c), 64'(imd_q[1]), 64'd0);
        end

        // Writeback stall of 5 cycles with a waiting issue
        tick();
        ex_valid  = 1'b0;
        result_ex = 32'd0;
        drive_issue(2'd2, ALU_ADD, MD_OP_DIV, 32'd100, 32'd7);
        for (int s = 0; s < 5; s++) begin
            if (s > 0) tick();
            imd_we   = 2'b11;
            imd_d[0] = 34'h0_0000_0055;
            #1;
            check($sformatf("stall%0d_wb_valid", s), 64'(wb_valid), 64'd1);
            check($sformatf("stall%0d_wb_result", s), 64'(wb_result), 64'd12);
            check($sformatf("stall%0d_issue_ready", s), 64'(issue_ready), 64'd0);
            check($sformatf("stall%0d_mult_en", s), 64'(mult_en), 64'd0);
            check($sformatf("stall%0d_imd0", s), 64'(imd_q[0]), 64'h1_2345_6789);
        end
        imd_we   = 2'b00;
        wb_ready = 1'b1;
        #1 check("b2b_issue_ready", 64'(issue_ready), 64'd1);

        // DIV accepted back-to-back, flushed in its 2nd EXEC cycle
        tick();
        quiet_inputs();
        imd_we   = 2'b10;
        imd_d[1] = 34'h2_0000_0001;
        #1;
        check("div_c1_state", 64'(ex_state), 64'(EX_EXEC));
        check("div_c1_en", 64'(div_en), 64'd1);
        check("div_c1_a", 64'(alu_a), 64'd100);
        check("div_c1_imd0_cleared", 64'(imd_q[0]), 64'd0);
        tick();
        imd_we    = 2'b00;
        flush     = 1'b1;
        ex_valid  = 1'b1;
        result_ex = 32'd14;
        issue_valid = 1'b1;
        #1;
        check("div_c2_imd1", 64'(imd_q[1]), 64'h2_0000_0001);
        check("div_c2_sel", 64'(div_sel), 64'd1);
        check("div_c2_en_flushed", 64'(div_en), 64'd0);
        check("div_c2_issue_ready", 64'(issue_ready), 64'd0);
        tick();
        quiet_inputs();
        #1;
        check("flush_state", 64'(ex_state), 64'(EX_IDLE));
        check("flush_wb_valid", 64'(wb_valid), 64'd0);
        check("flush_imd0", 64'(imd_q[0]), 64'd0);
        check("flush_imd1", 64'(imd_q[1]), 64'd0);
        tick();
        #1 check("flush_no_wb_later", 64'(wb_valid), 64'd0);

        // Illegal class 3 behaves as ALU
        drive_issue(2'd3, ALU_XOR, MD_OP_DIV, 32'h0F, 32'hF0);
        tick();
        quiet_inputs();
        #1;
        check("ill_state", 64'(ex_state), 64'(EX_EXEC));
        check("ill_mult_sel", 64'(mult_sel), 64'd0);
        check("ill_div_sel", 64'(div_sel), 64'd0);
        check("ill_first", 64'(first_cycle), 64'd1);

        // Asynchronous reset mid-EXEC
        #2 rst = 1'b1;
        #1;
        check("arst_state", 64'(ex_state), 64'(EX_IDLE));
        check("arst_first", 64'(first_cycle), 64'd0);
        check("arst_md_ready", 64'(md_ready_id), 64'd0);
        check("arst_wb_valid", 64'(wb_valid), 64'd0);
        #2 rst = 1'b0;
        tick();
        #1;
        check("arst_issue_ready", 64'(issue_ready), 64'd1);
        check("arst_no_wb", 64'(wb_valid), 64'd0);

`ifdef IBEX_XIF_EX_ISSUE_PERF_EN
        // 3 EXEC cycles then 2 writeback stall cycles
        drive_issue(2'd0, ALU_ADD, MD_OP_MULL, 32'd1, 32'd2);
        tick();
        quiet_inputs();
        tick();
        tick();
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        tick();
        tick();
        wb_ready = 1'b1;
        #1;
        check("perf_busy", 64'(perf_busy), 64'd3);
        check("perf_stall", 64'(perf_stall), 64'd2);
        tick();
        quiet_inputs();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
